// File: rtl/rob_commit_if.sv
// Dispatch, completion and retire signals of the reorder buffer.
// The dispatch/completion side uses master; the ROB uses slave.
interface rob_commit_if;
    logic        alloc_en;
    logic        alloc_has_dst;
    logic [7:0]  alloc_dst;
    logic [7:0]  alloc_tag;
    logic        alloc_reject;
    logic        complete_en;
    logic [56:0] complete_msg;
    logic        complete_reject;
    logic        commit_en;
    logic        commit_has_dst;
    logic [7:0]  commit_dst;
    logic [31:0] commit_value;
    logic [7:0]  commit_tag;
    logic        flash;
    logic [31:0] commit_count;

    modport master (
        output alloc_en, alloc_has_dst, alloc_dst, complete_en, complete_msg,
        input  alloc_tag, alloc_reject, complete_reject, commit_en, commit_has_dst,
               commit_dst, commit_value, commit_tag, flash, commit_count
    );

    modport slave (
        input  alloc_en, alloc_has_dst, alloc_dst, complete_en, complete_msg,
        output alloc_tag, alloc_reject, complete_reject, commit_en, commit_has_dst,
               commit_dst, commit_value, commit_tag, flash, commit_count
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit and exception flush pulse.
// Define ROB_COMMIT_COUNT_EN to enable the retired-instruction counter.
module rob_commit #(
    parameter int ROB_DEPTH = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    rob_commit_if.slave bus
);
    localparam int         IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam logic [8:0] FULL  = 9'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] done;
    logic                 has_dst_mem [ROB_DEPTH];
    logic [7:0]           dst_mem     [ROB_DEPTH];
    logic [31:0]          value_mem   [ROB_DEPTH];
    logic [7:0]           flags_mem   [ROB_DEPTH];
    logic [IDX_W-1:0]     head;
    logic [IDX_W-1:0]     tail;
    logic [8:0]           count;
    logic                 flash_q;

    logic                 commit_en_q;
    logic                 commit_has_dst_q;
    logic [7:0]           commit_dst_q;
    logic [31:0]          commit_value_q;
    logic [7:0]           commit_tag_q;

    logic [7:0]           comp_tag;
    logic [IDX_W-1:0]     comp_idx;
    logic                 comp_in_range;
    logic                 alloc_fire;
    logic                 comp_hit;
    logic                 head_ready;
    logic                 head_ok;
    logic                 head_exc;
    logic                 unused_msg_bits;

    // The completion's own dst fields are redundant: dispatch already recorded them.
    assign unused_msg_bits = ^bus.complete_msg[48:40];

    assign comp_tag      = bus.complete_msg[56:49];
    assign comp_idx      = comp_tag[IDX_W-1:0];
    assign comp_in_range = int'(comp_tag) < ROB_DEPTH;

    assign bus.alloc_reject    = (count == FULL) || flash_q;
    assign bus.complete_reject = flash_q;
    assign bus.alloc_tag       = 8'(tail);
    assign bus.flash           = flash_q;
    assign bus.commit_en       = commit_en_q;
    assign bus.commit_has_dst  = commit_has_dst_q;
    assign bus.commit_dst      = commit_dst_q;
    assign bus.commit_value    = commit_value_q;
    assign bus.commit_tag      = commit_tag_q;

    assign alloc_fire = bus.alloc_en && !bus.alloc_reject;
    assign comp_hit   = bus.complete_en && !flash_q && comp_in_range && valid[comp_idx];
    assign head_ready = valid[head] && done[head] && !flash_q;
    assign head_ok    = head_ready && (flags_mem[head] == 8'd0);
    assign head_exc   = head_ready && (flags_mem[head] != 8'd0);

    // head==tail with a valid head only when full, so alloc and retire never touch one slot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid            <= '0;
            done             <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            flash_q          <= 1'b0;
            commit_en_q      <= 1'b0;
            commit_has_dst_q <= 1'b0;
            commit_dst_q     <= '0;
            commit_value_q   <= '0;
            commit_tag_q     <= '0;
        end else if (flash_q) begin
            valid       <= '0;
            done        <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            flash_q     <= 1'b0;
            commit_en_q <= 1'b0;
        end else begin
            if (comp_hit) begin
                done[comp_idx] <= 1'b1;
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + 1'b1;
            end
            if (head_ok) begin
                valid[head]      <= 1'b0;
                head             <= head + 1'b1;
                commit_has_dst_q <= has_dst_mem[head];
                commit_dst_q     <= dst_mem[head];
                commit_value_q   <= value_mem[head];
                commit_tag_q     <= 8'(head);
            end
            if (head_exc) begin
                flash_q <= 1'b1;
            end
            commit_en_q <= head_ok;
            count       <= count + 9'(alloc_fire) - 9'(head_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            has_dst_mem[tail] <= bus.alloc_has_dst;
            dst_mem[tail]     <= bus.alloc_dst;
        end
        if (comp_hit) begin
            value_mem[comp_idx] <= bus.complete_msg[39:8];
            flags_mem[comp_idx] <= bus.complete_msg[7:0];
        end
    end

`ifdef ROB_COMMIT_COUNT_EN
    logic [31:0] commit_count_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            commit_count_q <= '0;
        end else if (head_ok) begin
            commit_count_q <= commit_count_q + 32'd1;
        end
    end

    assign bus.commit_count = commit_count_q;
`else
    assign bus.commit_count = 32'd0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed vector table, corner sequences,
// and random traffic against a queue-based model of the reorder buffer.
module tb_rob_commit;
    localparam int DEPTH = 32;
`ifdef ROB_COMMIT_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clock;
    logic reset_n;

    rob_commit_if bus ();

    rob_commit #(.ROB_DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [7:0]  tag;
        logic        has_dst;
        logic [7:0]  dst;
        logic        done;
        logic [31:0] value;
        logic [7:0]  flags;
    } rob_ent_t;

    typedef struct {
        bit          ae;
        bit          ahd;
        logic [7:0]  adst;
        bit          ce;
        logic [56:0] cmsg;
        bit          exp_cen;
        logic [7:0]  exp_ctag;
        logic [31:0] exp_cval;
        bit          exp_flash;
    } vec_t;

    // Program-order queue of live instructions plus the registered retire outputs.
    rob_ent_t    m_q[$];
    int          m_tail;
    bit          m_flash;
    bit          m_cen;
    bit          m_chd;
    logic [7:0]  m_cdst;
    logic [31:0] m_cval;
    logic [7:0]  m_ctag;
    logic [31:0] m_ccount;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [56:0] msg(input logic [7:0] tag, input logic [31:0] value,
                                        input logic [7:0] flags);
        return {tag, 1'b0, 8'd0, value, flags};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tail   = 0;
        m_flash  = 1'b0;
        m_cen    = 1'b0;
        m_chd    = 1'b0;
        m_cdst   = '0;
        m_cval   = '0;
        m_ctag   = '0;
        m_ccount = '0;
    endtask

    task automatic model_edge(input bit ae, input bit ahd, input logic [7:0] adst,
                              input bit ce, input logic [56:0] cmsg);
        bit       a_ok;
        bit       pop;
        rob_ent_t e;
        if (m_flash) begin
            m_q.delete();
            m_tail  = 0;
            m_flash = 1'b0;
            m_cen   = 1'b0;
            return;
        end
        a_ok  = ae && (m_q.size() < DEPTH);
        pop   = 1'b0;
        m_cen = 1'b0;
        if (m_q.size() > 0 && m_q[0].done) begin
            if (m_q[0].flags == 8'd0) begin
                pop    = 1'b1;
                m_cen  = 1'b1;
                m_chd  = m_q[0].has_dst;
                m_cdst = m_q[0].dst;
                m_cval = m_q[0].value;
                m_ctag = m_q[0].tag;
                if (CNT_ON) m_ccount = m_ccount + 32'd1;
            end else begin
                m_flash = 1'b1;
            end
        end
        if (ce) begin
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i].tag == cmsg[56:49]) begin
                    e       = m_q[i];
                    e.done  = 1'b1;
                    e.value = cmsg[39:8];
                    e.flags = cmsg[7:0];
                    m_q[i]  = e;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (a_ok) begin
            e.tag     = 8'(m_tail);
            e.has_dst = ahd;
            e.dst     = adst;
            e.done    = 1'b0;
            e.value   = '0;
            e.flags   = '0;
            m_q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic checkOutput();
        check("commit_en", bus.commit_en, m_cen);
        check("flash", bus.flash, m_flash);
        check("commit_tag", bus.commit_tag, m_ctag);
        check("commit_value", bus.commit_value, m_cval);
        check("commit_dst", bus.commit_dst, m_cdst);
        check("commit_has_dst", bus.commit_has_dst, m_chd);
        check("commit_count", bus.commit_count, m_ccount);
        check("alloc_tag", bus.alloc_tag, 8'(m_tail));
        check("alloc_reject", bus.alloc_reject, (m_q.size() == DEPTH) || m_flash);
        check("complete_reject", bus.complete_reject, m_flash);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input bit ae, input bit ahd, input logic [7:0] adst,
                                 input bit ce, input logic [56:0] cmsg);
        bus.alloc_en      = ae;
        bus.alloc_has_dst = ahd;
        bus.alloc_dst     = adst;
        bus.complete_en   = ce;
        bus.complete_msg  = cmsg;
        @(posedge clock);
        model_edge(ae, ahd, adst, ce, cmsg);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 57'd0);
    endtask

    task automatic do_reset();
        bus.alloc_en     = 1'b0;
        bus.complete_en  = 1'b0;
        bus.complete_msg = '0;
        reset_n          = 1'b0;
        @(posedge clock);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput();
    endtask

    vec_t vecs[10];

    initial begin
        reset_n           = 1'b0;
        bus.alloc_en      = 1'b0;
        bus.alloc_has_dst = 1'b0;
        bus.alloc_dst     = '0;
        bus.complete_en   = 1'b0;
        bus.complete_msg  = '0;

        vecs[0] = '{1, 1, 8'd1, 0, 57'd0,                   0, 8'd0, 32'h0, 0};
        vecs[1] = '{1, 1, 8'd2, 0, 57'd0,                   0, 8'd0, 32'h0, 0};
        vecs[2] = '{1, 1, 8'd3, 0, 57'd0,                   0, 8'd0, 32'h0, 0};
        vecs[3] = '{0, 0, 8'd0, 1, msg(8'd2, 32'hC, 8'd0),  0, 8'd0, 32'h0, 0};
        vecs[4] = '{0, 0, 8'd0, 1, msg(8'd1, 32'hB, 8'd0),  0, 8'd0, 32'h0, 0};
        vecs[5] = '{0, 0, 8'd0, 1, msg(8'd0, 32'hA, 8'd0),  0, 8'd0, 32'h0, 0};
        vecs[6] = '{0, 0, 8'd0, 0, 57'd0,                   1, 8'd0, 32'hA, 0};
        vecs[7] = '{0, 0, 8'd0, 0, 57'd0,                   1, 8'd1, 32'hB, 0};
        vecs[8] = '{0, 0, 8'd0, 0, 57'd0,                   1, 8'd2, 32'hC, 0};
        vecs[9] = '{0, 0, 8'd0, 0, 57'd0,                   0, 8'd0, 32'h0, 0};

        do_reset();
        check("reset_commit_en", bus.commit_en, 1'b0);
        check("reset_alloc_tag", bus.alloc_tag, 8'd0);

        // Out-of-order completion, in-order retire.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].ae, vecs[i].ahd, vecs[i].adst, vecs[i].ce, vecs[i].cmsg);
            check($sformatf("vec%0d_commit_en", i), bus.commit_en, vecs[i].exp_cen);
            check($sformatf("vec%0d_flash", i), bus.flash, vecs[i].exp_flash);
            if (vecs[i].exp_cen) begin
                check($sformatf("vec%0d_commit_tag", i), bus.commit_tag, vecs[i].exp_ctag);
                check($sformatf("vec%0d_commit_value", i), bus.commit_value, vecs[i].exp_cval);
            end
        end

        // Fill to capacity, free one slot, then raise an exception at the head.
        do_reset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 57'd0);
        check("full_alloc_reject", bus.alloc_reject, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, msg(8'd0, 32'hA0, 8'd0));
        check("full_not_yet_freed", bus.alloc_reject, 1'b1);
        idle(1);
        check("full_commit_tag0", bus.commit_en, 1'b1);
        check("full_freed_reject", bus.alloc_reject, 1'b0);
        check("full_wrap_tag", bus.alloc_tag, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, msg(8'd1, 32'hB1, 8'h01));
        idle(1);
        check("exc_flash_high", bus.flash, 1'b1);
        check("exc_commit_en", bus.commit_en, 1'b0);
        check("exc_alloc_reject", bus.alloc_reject, 1'b1);
        check("exc_complete_reject", bus.complete_reject, 1'b1);
        idle(1);
        check("exc_flash_low", bus.flash, 1'b0);
        check("exc_alloc_tag", bus.alloc_tag, 8'd0);
        check("exc_alloc_reject_after", bus.alloc_reject, 1'b0);

        // Completion to a tag that is not live is dropped.
        do_reset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 57'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, msg(8'd5, 32'h55, 8'd0));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'(i + 3), 1'b1, msg(8'(i), 32'(i), 8'd0));
        idle(4);
        check("drop_no_commit", bus.commit_en, 1'b0);
        check("drop_last_tag", bus.commit_tag, 8'd2);

        // Retired-instruction counter across a flush and a reset during flash.
        do_reset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 57'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, msg(8'(i), 32'(100 + i), 8'd0));
        idle(3);
        check("count_ten", bus.commit_count, CNT_ON ? 32'd10 : 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 57'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, msg(8'd10, 32'h0, 8'h02));
        idle(2);
        check("count_after_flush", bus.commit_count, CNT_ON ? 32'd10 : 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 57'd0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, msg(8'd0, 32'h0, 8'h04));
        idle(1);
        check("rst_flash_high", bus.flash, 1'b1);
        do_reset();
        check("rst_flash", bus.flash, 1'b0);
        check("rst_alloc_tag", bus.alloc_tag, 8'd0);
        check("rst_count", bus.commit_count, 32'd0);
        check("rst_commit_value", bus.commit_value, 32'd0);

        // Random traffic with rare exceptions and resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          ae;
            bit          ce;
            logic [7:0]  tag;
            logic [7:0]  flags;
            if ($urandom_range(499, 0) == 0) begin
                do_reset();
            end else begin
                ae = ($urandom_range(3, 0) != 0);
                ce = ($urandom_range(2, 0) != 0);
                if (m_q.size() > 0 && $urandom_range(7, 0) != 0)
                    tag = m_q[$urandom_range(m_q.size() - 1, 0)].tag;
                else
                    tag = 8'($urandom_range(DEPTH - 1, 0));
                flags = ($urandom_range(59, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
                applyStimulus(ae, 1'($urandom), 8'($urandom), ce, msg(tag, $urandom, flags));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
